// File: rtl/imem_region_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_region_ctrl
// Purpose  : Routes CPU instruction fetches to one of NUM_MEM memories by
//            address region and returns the instruction RD_LAT cycles later.
//            Define IMEM_FAULT_CNT_EN to add fault_cnt, a saturating count
//            of fetches to unmapped addresses.
// Revision : 1.0  initial release
// ============================================================================
module imem_region_ctrl #(
   parameter int                         NUM_MEM = 2,
   parameter int                         ADDR_W  = 32,
   parameter int                         DATA_W  = 32,
   parameter int                         RD_LAT  = 1,
   parameter logic [NUM_MEM*ADDR_W-1:0]  BASE    = {32'h0000_2000, 32'h0000_2800},
   parameter logic [NUM_MEM*ADDR_W-1:0]  SIZE    = {32'h0000_4000, 32'h0000_3800}
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cpu_req,
   input  logic [ADDR_W-1:0]             cpu_addr,
   output logic                          cpu_gnt,
   output logic [DATA_W-1:0]             instr_o,
   output logic                          instr_valid,
   output logic                          instr_fault,
   output logic [NUM_MEM-1:0]            mem_rd,
   output logic [NUM_MEM*ADDR_W-1:0]     mem_addr_o,
`ifdef IMEM_FAULT_CNT_EN
   output logic [7:0]                    fault_cnt,
`endif
   input  logic [NUM_MEM*DATA_W-1:0]     mem_data_i
);

   localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              fault_q, fault_d;

   logic [ADDR_W:0]   addr_x;
   logic [NUM_MEM-1:0] hit;
   logic              hit_any;
   logic [SEL_W-1:0]  sel;
   logic              accept;
   logic [DATA_W-1:0] rd_data [NUM_MEM];

   assign addr_x = {1'b0, cpu_addr};

   // Region bounds use one extra bit so a region ending at 2^ADDR_W cannot wrap.
   for (genvar i = 0; i < NUM_MEM; i++) begin : g_region
      logic [ADDR_W:0] base_x;
      logic [ADDR_W:0] end_x;
      assign base_x  = {1'b0, BASE[i*ADDR_W +: ADDR_W]};
      assign end_x   = base_x + {1'b0, SIZE[i*ADDR_W +: ADDR_W]};
      assign hit[i]  = (addr_x >= base_x) && (addr_x < end_x);
      assign mem_addr_o[i*ADDR_W +: ADDR_W] = cpu_addr - BASE[i*ADDR_W +: ADDR_W];
      assign rd_data[i] = mem_data_i[i*DATA_W +: DATA_W];
   end

   // Lowest matching index wins on overlap.
   always_comb begin
      sel = '0;
      for (int i = NUM_MEM - 1; i >= 0; i--) begin
         if (hit[i]) sel = SEL_W'(i);
      end
   end

   assign hit_any = |hit;
   assign accept  = cpu_req && cpu_gnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      fault_d = fault_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               fault_d = !hit_any;
               if (hit_any) sel_d = sel;
               if (hit_any && (RD_LAT > 1)) begin
                  state_d = S_WAIT;
                  cnt_d   = LAT_INIT;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
      endcase
   end

   always_comb begin
      cpu_gnt     = rst && (state_q != S_WAIT);
      instr_valid = (state_q == S_RESP);
      instr_fault = instr_valid && fault_q;
      instr_o     = (instr_valid && !fault_q) ? rd_data[sel_q] : '0;
      mem_rd      = '0;
      if (accept && hit_any) mem_rd[sel] = 1'b1;
   end

`ifdef IMEM_FAULT_CNT_EN
   logic [7:0] fault_cnt_q, fault_cnt_d;

   always_comb begin
      fault_cnt_d = fault_cnt_q;
      if (accept && !hit_any && (fault_cnt_q != 8'hFF)) fault_cnt_d = fault_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fault_cnt_q <= 8'd0;
      else      fault_cnt_q <= fault_cnt_d;
   end

   assign fault_cnt = fault_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_region_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_region_ctrl
// Purpose  : Directed bench for imem_region_ctrl at RD_LAT=1 and RD_LAT=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_region_ctrl;

   logic clk = 1'b0;
   logic rst;

   logic        req1, req3;
   logic [31:0] addr1, addr3;
   logic        gnt1, gnt3;
   logic [31:0] instr1, instr3;
   logic        valid1, valid3;
   logic        fault1, fault3;
   logic [1:0]  rd1, rd3;
   logic [63:0] maddr1, maddr3;
   logic [63:0] mdata1, mdata3;
`ifdef IMEM_FAULT_CNT_EN
   logic [7:0]  fc1, fc3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imem_region_ctrl #(.RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .cpu_req(req1), .cpu_addr(addr1), .cpu_gnt(gnt1),
      .instr_o(instr1), .instr_valid(valid1), .instr_fault(fault1),
      .mem_rd(rd1), .mem_addr_o(maddr1),
`ifdef IMEM_FAULT_CNT_EN
      .fault_cnt(fc1),
`endif
      .mem_data_i(mdata1)
   );

   imem_region_ctrl #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .cpu_req(req3), .cpu_addr(addr3), .cpu_gnt(gnt3),
      .instr_o(instr3), .instr_valid(valid3), .instr_fault(fault3),
      .mem_rd(rd3), .mem_addr_o(maddr3),
`ifdef IMEM_FAULT_CNT_EN
      .fault_cnt(fc3),
`endif
      .mem_data_i(mdata3)
   );

   // Memory models: data = {0xA0+port, 0x00, local_addr[15:0]}, RD_LAT after the strobe.
   function automatic logic [31:0] mdat(input int i, input logic [31:0] loc);
      return {8'hA0 + 8'(i), 8'h00, loc[15:0]};
   endfunction

   logic [31:0] m1_q [2];
   logic [31:0] p0_q [2];
   logic [31:0] p1_q [2];
   logic [31:0] p2_q [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m1_q[i] <= rd1[i] ? mdat(i, maddr1[i*32 +: 32]) : 32'h0;
         p0_q[i] <= rd3[i] ? mdat(i, maddr3[i*32 +: 32]) : 32'h0;
         p1_q[i] <= p0_q[i];
         p2_q[i] <= p1_q[i];
      end
   end

   assign mdata1 = {m1_q[1], m1_q[0]};
   assign mdata3 = {p2_q[1], p2_q[0]};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; req1 = 1'b0; addr1 = '0; req3 = 1'b0; addr3 = '0;

      // Reset state; request during reset is ignored
      @(negedge clk); req1 = 1'b1; addr1 = 32'h0000_2804; #1;
      chk("rst_gnt",   64'(gnt1),   64'd0);
      chk("rst_valid", 64'(valid1), 64'd0);
      chk("rst_fault", 64'(fault1), 64'd0);
      chk("rst_instr", 64'(instr1), 64'd0);
      chk("rst_memrd", 64'(rd1),    64'd0);
      chk("rst_gnt3",  64'(gnt3),   64'd0);

      // First accept on first edge after release
      @(negedge clk); rst = 1'b1; #1;
      chk("acc2804_gnt",   64'(gnt1), 64'd1);
      chk("acc2804_memrd", 64'(rd1),  64'b01);
      chk("acc2804_maddr", maddr1,    64'h0000_0804_0000_0004);
      @(negedge clk); req1 = 1'b0; #1;
      chk("rsp2804_valid", 64'(valid1), 64'd1);
      chk("rsp2804_fault", 64'(fault1), 64'd0);
      chk("rsp2804_instr", 64'(instr1), 64'hA000_0004);
      chk("rsp2804_gnt",   64'(gnt1),   64'd1);
      @(negedge clk); #1;
      chk("idle_valid", 64'(valid1), 64'd0);
      chk("idle_instr", 64'(instr1), 64'd0);

      req1 = 1'b1; addr1 = 32'h0000_2000; #1;
      chk("acc2000_memrd", 64'(rd1), 64'b10);
      chk("acc2000_maddr", maddr1,   64'h0000_0000_FFFF_F800);
      @(negedge clk); req1 = 1'b0; #1;
      chk("rsp2000_valid", 64'(valid1), 64'd1);
      chk("rsp2000_instr", 64'(instr1), 64'hA100_0000);

      @(negedge clk); req1 = 1'b1; addr1 = 32'h0000_1FFC; #1;
      chk("acc1ffc_memrd", 64'(rd1),  64'b00);
      chk("acc1ffc_gnt",   64'(gnt1), 64'd1);
      @(negedge clk); req1 = 1'b0; #1;
      chk("rsp1ffc_valid", 64'(valid1), 64'd1);
      chk("rsp1ffc_fault", 64'(fault1), 64'd1);
      chk("rsp1ffc_instr", 64'(instr1), 64'd0);

      // Boundaries, back-to-back at RD_LAT=1
      @(negedge clk); req1 = 1'b1; addr1 = 32'h0000_5FFC; #1;
      chk("idle2_fault",   64'(fault1), 64'd0);
      chk("acc5ffc_memrd", 64'(rd1),    64'b01);
      @(negedge clk); addr1 = 32'h0000_6000; #1;
      chk("rsp5ffc_valid", 64'(valid1), 64'd1);
      chk("rsp5ffc_instr", 64'(instr1), 64'hA000_37FC);
      chk("acc6000_memrd", 64'(rd1),    64'b00);
      @(negedge clk); addr1 = 32'h0000_27FC; #1;
      chk("rsp6000_valid", 64'(valid1), 64'd1);
      chk("rsp6000_fault", 64'(fault1), 64'd1);
      chk("rsp6000_instr", 64'(instr1), 64'd0);
      chk("acc27fc_memrd", 64'(rd1),    64'b10);
      chk("acc27fc_maddr", maddr1,      64'h0000_07FC_FFFF_FFFC);
      @(negedge clk); req1 = 1'b0; #1;
      chk("rsp27fc_valid", 64'(valid1), 64'd1);
      chk("rsp27fc_fault", 64'(fault1), 64'd0);
      chk("rsp27fc_instr", 64'(instr1), 64'hA100_07FC);

      // RD_LAT=3: wait states, ignored request, back-to-back
      @(negedge clk); req3 = 1'b1; addr3 = 32'h0000_2900; #1;
      chk("l3_acc_gnt",   64'(gnt3), 64'd1);
      chk("l3_acc_memrd", 64'(rd3),  64'b01);
      @(negedge clk); addr3 = 32'h0000_2A00; #1;
      chk("l3_w1_gnt",   64'(gnt3),   64'd0);
      chk("l3_w1_valid", 64'(valid3), 64'd0);
      chk("l3_w1_memrd", 64'(rd3),    64'b00);
      @(negedge clk); #1;
      chk("l3_w2_gnt",   64'(gnt3),   64'd0);
      chk("l3_w2_valid", 64'(valid3), 64'd0);
      chk("l3_w2_memrd", 64'(rd3),    64'b00);
      @(negedge clk); addr3 = 32'h0000_2904; #1;
      chk("l3_rsp_valid", 64'(valid3), 64'd1);
      chk("l3_rsp_instr", 64'(instr3), 64'hA000_0100);
      chk("l3_rsp_gnt",   64'(gnt3),   64'd1);
      chk("l3_b2b_memrd", 64'(rd3),    64'b01);
      @(negedge clk); req3 = 1'b0; #1;
      chk("l3_b1_valid", 64'(valid3), 64'd0);
      chk("l3_b1_gnt",   64'(gnt3),   64'd0);
      @(negedge clk); #1;
      chk("l3_b2_valid", 64'(valid3), 64'd0);
      @(negedge clk); #1;
      chk("l3_b3_valid", 64'(valid3), 64'd1);
      chk("l3_b3_instr", 64'(instr3), 64'hA000_0104);
      @(negedge clk); #1;
      chk("l3_end_valid", 64'(valid3), 64'd0);
      chk("l3_end_gnt",   64'(gnt3),   64'd1);

      // Reset pulsed during WAIT discards the fetch
      req3 = 1'b1; addr3 = 32'h0000_2900; #1;
      chk("rw_acc_memrd", 64'(rd3), 64'b01);
      @(negedge clk); req3 = 1'b0; #1;
      chk("rw_wait_gnt", 64'(gnt3), 64'd0);
      rst = 1'b0; #1;
      chk("rw_rst_gnt",   64'(gnt3),   64'd0);
      chk("rw_rst_valid", 64'(valid3), 64'd0);
      chk("rw_rst_instr", 64'(instr3), 64'd0);
      chk("rw_rst_memrd", 64'(rd3),    64'd0);
      chk("rw_rst_gnt1",  64'(gnt1),   64'd0);
      @(negedge clk); rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("rw_post_valid", 64'(valid3), 64'd0);
      end
      chk("rw_post_gnt", 64'(gnt3), 64'd1);

`ifdef IMEM_FAULT_CNT_EN
      @(negedge clk); rst = 1'b0; #1;
      chk("fc_rst0", 64'(fc1), 64'd0);
      @(negedge clk); rst = 1'b1; req1 = 1'b1; addr1 = 32'h0000_0100;
      repeat (300) @(negedge clk);
      req1 = 1'b0; #1;
      chk("fc_sat", 64'(fc1), 64'hFF);
      chk("fc_other", 64'(fc3), 64'd0);
      rst = 1'b0; #1;
      chk("fc_rst1", 64'(fc1), 64'd0);
      @(negedge clk); rst = 1'b1;
`endif

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
